// File: rtl/window_addr_gen_pkg.sv
// window_addr_gen_pkg: shared types and constants
// for the 5x5 sliding-window address generator.
package window_addr_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT_PROC,
    WRITE,
    DONE
  } state_t;

  localparam int WIN_SIZE   = 5;
  localparam int WIN_STRIDE = 3;
  localparam int WR_PER_WIN = 3;

  // Counter width for a modulo-n count, at least 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/window_addr_gen_wrap_counter.sv
// wag_wrap_counter: modulo-N up-counter with enable,
// synchronous clear and a wrap strobe.
//
// Ports:
//   clk, n_rst : clock, sync active-low reset
//   clr        : force count to 0 (priority over en)
//   en         : advance by one
//   cnt        : current registered count
//   nxt        : value cnt takes at the next edge
//   wrap       : en while cnt == N-1
module wag_wrap_counter
  import window_addr_gen_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt,
  output logic         wrap
);

  assign wrap = en && (cnt == W'(N - 1));

  always_comb begin
    nxt = cnt;
    if (clr)
      nxt = '0;
    else if (en)
      nxt = wrap ? '0 : cnt + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!n_rst)
      cnt <= '0;
    else
      cnt <= nxt;
  end

endmodule

// File: rtl/window_addr_gen.sv
// window_addr_gen: walks 5x5 windows (stride 3) over
// an image, issuing 25 reads and 3 writes per window.
//
// Ports:
//   clk, n_rst     : clock, sync active-low reset
//   i_start        : frame start (IDLE only)
//   i_abort        : frame abort (WINDOW_ADDR_GEN_ABORT_EN)
//   i_rd_ack       : read of o_raddr completed
//   i_proc_done    : window results ready
//   i_wr_ack       : write of o_waddr completed
//   o_raddr, o_re  : read address / valid
//   o_waddr, o_we  : write address / valid
//   o_win_loaded   : pulse after 25th read ack
//   o_frame_done   : pulse at frame end
//   o_busy         : not IDLE
// Macro WINDOW_ADDR_GEN_ABORT_EN enables i_abort.
module window_addr_gen
  import window_addr_gen_pkg::*;
#(
  parameter int          IMG_W   = 32,
  parameter int          IMG_H   = 32,
  parameter logic [31:0] RD_BASE = 32'h0000_0000,
  parameter logic [31:0] WR_BASE = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_rd_ack,
  input  logic        i_proc_done,
  input  logic        i_wr_ack,
  output logic [31:0] o_raddr,
  output logic        o_re,
  output logic [31:0] o_waddr,
  output logic        o_we,
  output logic        o_win_loaded,
  output logic        o_frame_done,
  output logic        o_busy
);

  localparam int NX =
    (IMG_W - WIN_SIZE) / WIN_STRIDE + 1;
  localparam int NY =
    (IMG_H - WIN_SIZE) / WIN_STRIDE + 1;
  localparam int RC_W = cnt_w(WIN_SIZE);
  localparam int X_W  = cnt_w(NX);
  localparam int Y_W  = cnt_w(NY);
  localparam int K_W  = cnt_w(WR_PER_WIN);
  localparam logic [31:0] W32 = 32'(IMG_W);
  localparam logic [31:0] S32 = 32'(WIN_STRIDE);

  if ((IMG_W - 2) % 3 != 0 || (IMG_H - 2) % 3 != 0 ||
      IMG_W < 5 || IMG_H < 5) begin : g_bad_cfg
    $fatal(1, "window_addr_gen: bad IMG_W/IMG_H");
  end

  state_t state;
  state_t state_nxt;

  logic            abort_hit;
  logic            clr;
  logic [RC_W-1:0] c_cnt, c_nxt, r_cnt, r_nxt;
  logic [X_W-1:0]  x_cnt, x_nxt;
  logic [Y_W-1:0]  y_cnt, y_nxt;
  logic [K_W-1:0]  k_cnt, k_nxt;
  logic            c_en, c_wrap, r_wrap;
  logic            k_en, k_wrap, x_wrap, y_wrap;
  logic            last_rd, last_wr;
  logic [31:0]     n, n_nxt;
  logic [31:0]     rd_nxt, wr_nxt;
  logic            unused_cnt;

`ifdef WINDOW_ADDR_GEN_ABORT_EN
  assign abort_hit = i_abort && (state != IDLE);
`else
  logic unused_abort;
  assign unused_abort = i_abort;
  assign abort_hit    = 1'b0;
`endif

  // Counters sit at zero while idle, so a start
  // always begins from window (0,0).
  assign clr     = (state == IDLE) || abort_hit;
  assign c_en    = o_re && i_rd_ack;
  assign k_en    = o_we && i_wr_ack;
  assign last_rd = r_wrap;
  assign last_wr = k_wrap;

  wag_wrap_counter #(.N(WIN_SIZE), .W(RC_W)) u_c (
    .clk(clk), .n_rst(n_rst), .clr(clr),
    .en(c_en), .cnt(c_cnt), .nxt(c_nxt),
    .wrap(c_wrap)
  );

  wag_wrap_counter #(.N(WIN_SIZE), .W(RC_W)) u_r (
    .clk(clk), .n_rst(n_rst), .clr(clr),
    .en(c_wrap), .cnt(r_cnt), .nxt(r_nxt),
    .wrap(r_wrap)
  );

  wag_wrap_counter #(.N(NX), .W(X_W)) u_wx (
    .clk(clk), .n_rst(n_rst), .clr(clr),
    .en(k_wrap), .cnt(x_cnt), .nxt(x_nxt),
    .wrap(x_wrap)
  );

  wag_wrap_counter #(.N(NY), .W(Y_W)) u_wy (
    .clk(clk), .n_rst(n_rst), .clr(clr),
    .en(x_wrap), .cnt(y_cnt), .nxt(y_nxt),
    .wrap(y_wrap)
  );

  wag_wrap_counter #(.N(WR_PER_WIN), .W(K_W)) u_k (
    .clk(clk), .n_rst(n_rst), .clr(clr),
    .en(k_en), .cnt(k_cnt), .nxt(k_nxt),
    .wrap(k_wrap)
  );

  assign unused_cnt =
    ^{c_cnt, r_cnt, x_cnt, y_cnt, k_cnt, k_nxt};

  assign n_nxt = clr  ? '0 :
                 k_en ? n + 32'd1 : n;

  // Addresses are formed from the counters' next
  // values so they register alongside the state.
  assign rd_nxt = RD_BASE +
    (((32'(y_nxt) * S32 + 32'(r_nxt)) * W32 +
      32'(x_nxt) * S32 + 32'(c_nxt)) << 2);
  assign wr_nxt = WR_BASE + (n_nxt << 2);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (i_start) state_nxt = READ;
      READ:
        if (last_rd) state_nxt = WAIT_PROC;
      WAIT_PROC:
        if (i_proc_done) state_nxt = WRITE;
      WRITE:
        if (last_wr)
          state_nxt = y_wrap ? DONE : READ;
      DONE:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      n            <= '0;
      o_raddr      <= '0;
      o_waddr      <= '0;
      o_re         <= 1'b0;
      o_we         <= 1'b0;
      o_win_loaded <= 1'b0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state        <= state_nxt;
      n            <= n_nxt;
      o_re         <= (state_nxt == READ);
      o_we         <= (state_nxt == WRITE);
      o_busy       <= (state_nxt != IDLE);
      o_win_loaded <= last_rd && !abort_hit;
      o_frame_done <= (state_nxt == DONE);
      if (state_nxt == READ)  o_raddr <= rd_nxt;
      if (state_nxt == WRITE) o_waddr <= wr_nxt;
    end
  end

endmodule

// File: tb/tb_window_addr_gen.sv
// tb_window_addr_gen: randomized scoreboard bench
// for window_addr_gen (default 32x32 image).
module tb_window_addr_gen;

  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam logic [31:0] RD_BASE = 32'h0000_0000;
  localparam logic [31:0] WR_BASE = 32'h0001_0000;
  localparam int NX   = (IMG_W - 5) / 3 + 1;
  localparam int NY   = (IMG_H - 5) / 3 + 1;
  localparam int NWIN = NX * NY;
  localparam int NRD  = NWIN * 25;
  localparam int NWR  = NWIN * 3;
  localparam int BUDGET = 40000;

  logic        clk;
  logic        n_rst;
  logic        i_start, i_abort;
  logic        i_rd_ack, i_proc_done, i_wr_ack;
  logic [31:0] o_raddr, o_waddr;
  logic        o_re, o_we;
  logic        o_win_loaded, o_frame_done, o_busy;

  window_addr_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H),
    .RD_BASE(RD_BASE), .WR_BASE(WR_BASE)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .i_start(i_start), .i_abort(i_abort),
    .i_rd_ack(i_rd_ack),
    .i_proc_done(i_proc_done),
    .i_wr_ack(i_wr_ack),
    .o_raddr(o_raddr), .o_re(o_re),
    .o_waddr(o_waddr), .o_we(o_we),
    .o_win_loaded(o_win_loaded),
    .o_frame_done(o_frame_done),
    .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_rd[$];
  logic [31:0] exp_wr[$];

  int rd_cnt, wr_cnt, wl_cnt, fd_cnt, rd_in_win;
  bit pend_wl, pend_fd, prev_stall;
  logic [31:0] prev_raddr, last_wa;
  bit rnd;
  int hold_rd;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h",
               name, act, exp);
    end
  endtask

  task automatic fail_now(input string name,
                          input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=0x%0h required=none",
             name, act);
  endtask

  task automatic sb_clear();
    exp_rd.delete();
    exp_wr.delete();
    rd_cnt = 0; wr_cnt = 0;
    wl_cnt = 0; fd_cnt = 0;
    rd_in_win = 0;
    pend_wl = 0; pend_fd = 0;
    prev_stall = 0;
    last_wa = '0;
  endtask

  // Reference: windows stride 3 in x then y,
  // pixels row-major, writes numbered frame-wide.
  task automatic model_push();
    for (int wy = 0; wy <= IMG_H - 5; wy += 3)
      for (int wx = 0; wx <= IMG_W - 5; wx += 3)
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++)
            exp_rd.push_back(RD_BASE +
              32'(4 * ((wy + r) * IMG_W + wx + c)));
    for (int k = 0; k < NWR; k++)
      exp_wr.push_back(WR_BASE + 32'(4 * k));
  endtask

  always @(negedge clk) begin
    if (!n_rst) begin
      prev_stall = 0;
    end else begin
      chk("re_we_excl", 32'(o_re & o_we), 32'd0);
      chk("win_loaded", 32'(o_win_loaded),
          32'(pend_wl));
      pend_wl = 0;
      chk("frame_done", 32'(o_frame_done),
          32'(pend_fd));
      pend_fd = 0;
      if (o_win_loaded) wl_cnt++;
      if (o_frame_done) fd_cnt++;
      if (prev_stall && o_re)
        chk("raddr_hold", o_raddr, prev_raddr);
      prev_stall = o_re && !i_rd_ack;
      prev_raddr = o_raddr;
      if (o_re && i_rd_ack) begin
        if (exp_rd.size() == 0)
          fail_now("rd_unexpected", o_raddr);
        else
          chk("raddr", o_raddr, exp_rd.pop_front());
        rd_cnt++;
        rd_in_win++;
        if (rd_in_win == 25) begin
          pend_wl = 1;
          rd_in_win = 0;
        end
      end
      if (o_we && i_wr_ack) begin
        if (exp_wr.size() == 0)
          fail_now("wr_unexpected", o_waddr);
        else
          chk("waddr", o_waddr, exp_wr.pop_front());
        last_wa = o_waddr;
        wr_cnt++;
        if (wr_cnt == NWR) pend_fd = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_abort = 1'b0;
    if (hold_rd > 0) begin
      i_rd_ack = 1'b0;
      hold_rd--;
    end else begin
      i_rd_ack = rnd ? ($urandom_range(3) != 0) : 1'b1;
    end
    i_wr_ack = rnd ? ($urandom_range(2) != 0) : 1'b1;
    i_proc_done = rnd ? ($urandom_range(3) == 0) : 1'b1;
    if (rnd && o_busy && !o_frame_done &&
        $urandom_range(7) == 0)
      i_start = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_raddr"}, o_raddr, 32'd0);
    chk({tag, "_waddr"}, o_waddr, 32'd0);
    chk({tag, "_re"}, 32'(o_re), 32'd0);
    chk({tag, "_we"}, 32'(o_we), 32'd0);
    chk({tag, "_wl"}, 32'(o_win_loaded), 32'd0);
    chk({tag, "_fd"}, 32'(o_frame_done), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  // mode 0 plain, 1 reset in window 5 write,
  // 2 abort in READ, 3 seven-cycle read stall
  task automatic run_frame(input bit rnd_i,
                           input int mode);
    int cyc;
    bit done, inj, full;
    sb_clear();
    model_push();
    rnd = rnd_i;
    i_start = 1'b1;
    step();
    chk("start_re", 32'(o_re), 32'd1);
    chk("start_raddr", o_raddr, RD_BASE);
    cyc = 0; done = 0; inj = 0;
    full = (mode == 0 || mode == 3);
`ifndef WINDOW_ADDR_GEN_ABORT_EN
    if (mode == 2) full = 1;
`endif
    while (!done && cyc < BUDGET) begin
      cyc++;
      if (mode == 3 && !inj && o_re &&
          rd_cnt == 37) begin
        inj = 1;
        hold_rd = 7;
        step();
      end else if (mode == 1 && !inj &&
                   wl_cnt == 6 && o_we) begin
        inj = 1;
        n_rst = 1'b0;
        step();
        chk_zero("midwr_rst");
        n_rst = 1'b1;
        sb_clear();
        step();
        chk("post_rst_busy", 32'(o_busy), 32'd0);
        done = 1;
      end else if (mode == 2 && !inj && o_re &&
                   rd_cnt >= 40 && rd_in_win > 3 &&
                   rd_in_win < 20) begin
        inj = 1;
        i_abort = 1'b1;
        step();
`ifdef WINDOW_ADDR_GEN_ABORT_EN
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_re", 32'(o_re), 32'd0);
        chk("abort_we", 32'(o_we), 32'd0);
        sb_clear();
        repeat (30) step();
        chk("abort_no_fd", 32'(fd_cnt), 32'd0);
        chk("abort_idle", 32'(o_busy), 32'd0);
        done = 1;
`endif
      end else begin
        step();
        if (fd_cnt > 0) done = 1;
      end
    end
    if (!done) fail_now("frame_timeout", 32'(cyc));
    if (full && done) begin
      repeat (3) step();
      chk("n_reads", 32'(rd_cnt), 32'(NRD));
      chk("n_writes", 32'(wr_cnt), 32'(NWR));
      chk("n_win_loaded", 32'(wl_cnt), 32'(NWIN));
      chk("n_frame_done", 32'(fd_cnt), 32'd1);
      chk("last_waddr", last_wa,
          WR_BASE + 32'(4 * (NWR - 1)));
      chk("rd_left", 32'(exp_rd.size()), 32'd0);
      chk("wr_left", 32'(exp_wr.size()), 32'd0);
      chk("end_busy", 32'(o_busy), 32'd0);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    i_start = 1'b0; i_abort = 1'b0;
    i_rd_ack = 1'b0; i_proc_done = 1'b0;
    i_wr_ack = 1'b0;
    rnd = 0; hold_rd = 0;
    sb_clear();
    repeat (4) begin
      i_start = 1'b1;
      i_abort = 1'b1;
      step();
    end
    chk_zero("rst");
    n_rst = 1'b1;
    step();
    step();
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_re", 32'(o_re), 32'd0);

    run_frame(1'b0, 3);
    run_frame(1'b1, 0);
    run_frame(1'b1, 1);
    run_frame(1'b1, 0);
    run_frame(1'b1, 2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
